spi_target: RTL

SPI mode-0 target (slave) that receives bytes from the host MCU and presents them on the `spi_bus` slave modport to the command decoder, which in turn drives SDRAM. It oversamples the SPI pins in the `clk` domain, assembles MSB-first bytes, and signals byte completion and end of transaction. An optional transmit path shifts reply bytes out on MISO.

---
 rtl/spi_pkg.sv | 13 +
 rtl/spi_bus.sv | 13 +
 rtl/spi_target_cdc_sync.sv | 29 ++
 rtl/spi_target.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared constants and types for the SPI mode-0 target.
package spi_pkg;

   localparam int SPI_BYTE_W      = 8;
   localparam int SYNC_STAGES_MIN = 2;
   localparam int BIT_CNT_W       = $clog2(SPI_BYTE_W);

   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } spi_state_t;

endpackage

// File: rtl/spi_bus.sv
// Byte-level bus between the SPI target and the command decoder.
interface spi_bus;

   logic [spi_pkg::SPI_BYTE_W-1:0] read;
   logic                           read_valid;
   logic                           transm_end;
   logic [spi_pkg::SPI_BYTE_W-1:0] write;
   logic                           write_ready;

   modport slave  (output read, read_valid, transm_end, write_ready, input  write);
   modport master (input  read, read_valid, transm_end, write_ready, output write);

endinterface

// File: rtl/spi_target_cdc_sync.sv
// Single-bit multi-flop synchronizer with asynchronous active-high reset.
module cdc_sync #(
   parameter int   STAGES  = 2,
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d_i,
   output logic q_o
);

   logic [STAGES-1:0] chain_q;
   logic [STAGES-1:0] chain_d;

   always_comb begin
      chain_d = {chain_q[STAGES-2:0], d_i};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         chain_q <= {STAGES{RST_VAL}};
      end else begin
         chain_q <= chain_d;
      end
   end

   assign q_o = chain_q[STAGES-1];

endmodule

// File: rtl/spi_target.sv
// SPI mode-0 target: oversampled receive path plus optional MISO transmit path
// (transmit logic built only when SPI_TARGET_TX_EN is defined).
module spi_target
   import spi_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic   clk,
   input  logic   rst,
   input  logic   spi_sck,
   input  logic   spi_cs_n,
   input  logic   spi_mosi,
   output logic   spi_miso,
   output logic   spi_miso_oe,
   spi_bus.slave  spi
);

   localparam int SYNC_N  = (SYNC_STAGES < SYNC_STAGES_MIN) ? SYNC_STAGES_MIN : SYNC_STAGES;
   localparam int FLUSH_W = $clog2(SYNC_N + 1);

   logic sck_s, cs_n_s, mosi_s;

   cdc_sync #(.STAGES(SYNC_N), .RST_VAL(1'b0)) u_sync_sck  (.clk(clk), .rst(rst), .d_i(spi_sck),  .q_o(sck_s));
   cdc_sync #(.STAGES(SYNC_N), .RST_VAL(1'b1)) u_sync_cs   (.clk(clk), .rst(rst), .d_i(spi_cs_n), .q_o(cs_n_s));
   cdc_sync #(.STAGES(SYNC_N), .RST_VAL(1'b0)) u_sync_mosi (.clk(clk), .rst(rst), .d_i(spi_mosi), .q_o(mosi_s));

   spi_state_t            state_q, state_d;
   logic                  sck_prev_q, sck_prev_d;
   logic                  cs_n_prev_q, cs_n_prev_d;
   logic [FLUSH_W-1:0]    flush_cnt_q, flush_cnt_d;
   logic                  armed_q, armed_d;
   logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
   logic [SPI_BYTE_W-1:0] rx_shift_q, rx_shift_d;
   logic [SPI_BYTE_W-1:0] read_q, read_d;
   logic                  read_valid_q, read_valid_d;
   logic                  transm_end_q, transm_end_d;
   logic                  end_pending_q, end_pending_d;

   logic sck_rise_s, sck_fall_s, cs_fall_s, cs_rise_s, byte_done_s;

   // A CS low seen straight out of reset must not count as a start, so falls
   // are only honoured once a genuine high has propagated through the syncs.
   assign sck_rise_s  = sck_s & ~sck_prev_q;
   assign sck_fall_s  = ~sck_s & sck_prev_q;
   assign cs_fall_s   = armed_q & ~cs_n_s & cs_n_prev_q;
   assign cs_rise_s   = cs_n_s & ~cs_n_prev_q;
   assign byte_done_s = (state_q == ACTIVE) && sck_rise_s &&
                        (bit_cnt_q == BIT_CNT_W'(SPI_BYTE_W - 1));

   always_comb begin
      state_d       = state_q;
      sck_prev_d    = sck_s;
      cs_n_prev_d   = cs_n_s;
      flush_cnt_d   = flush_cnt_q;
      armed_d       = armed_q;
      bit_cnt_d     = bit_cnt_q;
      rx_shift_d    = rx_shift_q;
      read_d        = read_q;
      read_valid_d  = 1'b0;
      transm_end_d  = end_pending_q;
      end_pending_d = 1'b0;

      if (flush_cnt_q != FLUSH_W'(SYNC_N)) begin
         flush_cnt_d = flush_cnt_q + FLUSH_W'(1);
      end else if (cs_n_s) begin
         armed_d = 1'b1;
      end else begin
         armed_d = armed_q;
      end

      case (state_q)
         IDLE: begin
            if (cs_fall_s) begin
               state_d   = ACTIVE;
               bit_cnt_d = '0;
            end else begin
               state_d   = IDLE;
            end
         end
         ACTIVE: begin
            if (sck_rise_s) begin
               rx_shift_d = {rx_shift_q[SPI_BYTE_W-2:0], mosi_s};
               bit_cnt_d  = bit_cnt_q + BIT_CNT_W'(1);
            end else begin
               rx_shift_d = rx_shift_q;
            end
            if (byte_done_s) begin
               read_d       = {rx_shift_q[SPI_BYTE_W-2:0], mosi_s};
               read_valid_d = 1'b1;
            end else begin
               read_valid_d = 1'b0;
            end
            // End pulse is deferred a cycle when it coincides with the last byte.
            if (cs_rise_s) begin
               state_d = IDLE;
               if (byte_done_s) begin
                  end_pending_d = 1'b1;
               end else begin
                  transm_end_d  = 1'b1;
               end
            end else begin
               state_d = ACTIVE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         sck_prev_q    <= 1'b0;
         cs_n_prev_q   <= 1'b1;
         flush_cnt_q   <= '0;
         armed_q       <= 1'b0;
         bit_cnt_q     <= '0;
         rx_shift_q    <= '0;
         read_q        <= '0;
         read_valid_q  <= 1'b0;
         transm_end_q  <= 1'b0;
         end_pending_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         sck_prev_q    <= sck_prev_d;
         cs_n_prev_q   <= cs_n_prev_d;
         flush_cnt_q   <= flush_cnt_d;
         armed_q       <= armed_d;
         bit_cnt_q     <= bit_cnt_d;
         rx_shift_q    <= rx_shift_d;
         read_q        <= read_d;
         read_valid_q  <= read_valid_d;
         transm_end_q  <= transm_end_d;
         end_pending_q <= end_pending_d;
      end
   end

   assign spi.read       = read_q;
   assign spi.read_valid = read_valid_q;
   assign spi.transm_end = transm_end_q;

`ifdef SPI_TARGET_TX_EN
   logic [SPI_BYTE_W-1:0] tx_shift_q, tx_shift_d;
   logic                  skip_fall_q, skip_fall_d;
   logic                  write_ready_q, write_ready_d;
   logic                  miso_oe_q, miso_oe_d;

   // A wrap reload lands between the 8th rise and its fall; that fall must not
   // shift the freshly loaded MSB away.
   always_comb begin
      tx_shift_d    = tx_shift_q;
      skip_fall_d   = skip_fall_q;
      write_ready_d = 1'b0;
      miso_oe_d     = ~cs_n_s;
      if ((state_q == IDLE) && cs_fall_s) begin
         tx_shift_d    = spi.write;
         write_ready_d = 1'b1;
         skip_fall_d   = 1'b0;
      end else if (byte_done_s) begin
         tx_shift_d    = spi.write;
         write_ready_d = 1'b1;
         skip_fall_d   = 1'b1;
      end else if ((state_q == ACTIVE) && sck_fall_s) begin
         if (skip_fall_q) begin
            skip_fall_d = 1'b0;
         end else begin
            tx_shift_d  = {tx_shift_q[SPI_BYTE_W-2:0], 1'b0};
         end
      end else begin
         tx_shift_d = tx_shift_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_shift_q    <= '0;
         skip_fall_q   <= 1'b0;
         write_ready_q <= 1'b0;
         miso_oe_q     <= 1'b0;
      end else begin
         tx_shift_q    <= tx_shift_d;
         skip_fall_q   <= skip_fall_d;
         write_ready_q <= write_ready_d;
         miso_oe_q     <= miso_oe_d;
      end
   end

   assign spi_miso        = tx_shift_q[SPI_BYTE_W-1];
   assign spi_miso_oe     = miso_oe_q;
   assign spi.write_ready = write_ready_q;
`else
   logic unused_write_s;
   assign unused_write_s  = ^spi.write;
   assign spi_miso        = 1'b0;
   assign spi_miso_oe     = 1'b0;
   assign spi.write_ready = 1'b0;
`endif

endmodule
